// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard controller: forwarding selects,
// load-use stall and taken-branch flush for the ID instruction.
module pipe_hazard_unit #(
   parameter int RAWIDTH    = 5,
   parameter int FWD_DEPTH  = 3,
   parameter int LOAD_STALL = 1,
   parameter int SELW       = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [RAWIDTH-1:0] id_rs1,
   input  logic [RAWIDTH-1:0] id_rs2,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [RAWIDTH-1:0] id_rd,
   input  logic               id_regwen,
   input  logic               id_is_load,
   input  logic               br_taken,
   output logic               stall,
   output logic               flush_id,
   output logic               bubble_x,
   output logic [SELW-1:0]    fwd_a,
   output logic [SELW-1:0]    fwd_b,
   output logic               x_valid
);

   typedef struct packed {
      logic               valid;
      logic [RAWIDTH-1:0] rd;
      logic               regwen;
      logic               is_load;
   } slot_t;

   slot_t t [1:FWD_DEPTH];

   logic [SELW-1:0] sel_a, sel_b;
   logic            ld_a, ld_b;
   logic            flush, advance;

   // Scan oldest to nearest so the nearest match overwrites.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (t[k].valid && t[k].regwen && id_use_rs1 &&
             id_rs1 != '0 && t[k].rd == id_rs1) begin
            sel_a = SELW'(k);
            ld_a  = t[k].is_load && (k <= LOAD_STALL);
         end
         if (t[k].valid && t[k].regwen && id_use_rs2 &&
             id_rs2 != '0 && t[k].rd == id_rs2) begin
            sel_b = SELW'(k);
            ld_b  = t[k].is_load && (k <= LOAD_STALL);
         end
      end
   end

   assign x_valid  = t[1].valid;
   assign flush    = br_taken && x_valid;
   assign flush_id = flush;
   assign stall    = id_valid && !flush && (ld_a || ld_b);
   assign bubble_x = stall || flush;
   assign advance  = id_valid && !stall && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 1; k <= FWD_DEPTH; k++) begin
            t[k] <= '0;
         end
         fwd_a <= '0;
         fwd_b <= '0;
      end else begin
         for (int k = 2; k <= FWD_DEPTH; k++) begin
            t[k] <= t[k-1];
         end
         if (advance) begin
            t[1]  <= {1'b1, id_rd, id_regwen, id_is_load};
            fwd_a <= sel_a;
            fwd_b <= sel_b;
         end else begin
            t[1]  <= '0;
            fwd_a <= '0;
            fwd_b <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit; second instance
// runs with a two-cycle load-use bubble.
module tb_pipe_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2;
   logic       id_regwen, id_is_load;
   logic       br_taken;

   logic       stall, flush_id, bubble_x, x_valid;
   logic [1:0] fwd_a, fwd_b;
   logic       stall2, flush_id2, bubble_x2, x_valid2;
   logic [1:0] fwd_a2, fwd_b2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwen(id_regwen),
      .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(stall), .flush_id(flush_id),
      .bubble_x(bubble_x), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .x_valid(x_valid)
   );

   pipe_hazard_unit #(.LOAD_STALL(2)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_regwen(id_regwen),
      .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(stall2), .flush_id(flush_id2),
      .bubble_x(bubble_x2), .fwd_a(fwd_a2),
      .fwd_b(fwd_b2), .x_valid(x_valid2)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic ins(input logic v,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic w,
                      input logic l);
      id_valid   = v;
      id_rs1     = r1;
      id_use_rs1 = u1;
      id_rs2     = r2;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_regwen  = w;
      id_is_load = l;
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic nop();
      ins(0, 0, 0, 0, 0, 0, 0, 0);
      go();
   endtask

   task automatic drain();
      for (int i = 0; i < 5; i++) nop();
   endtask

   initial begin
      rst = 1'b0;
      br_taken = 1'b1;
      ins(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("rst_stall", stall, 0);
      check("rst_flush", flush_id, 0);
      check("rst_bubble", bubble_x, 0);
      check("rst_fwd_a", fwd_a, 0);
      check("rst_fwd_b", fwd_b, 0);
      check("rst_xvalid", x_valid, 0);
      mid();
      rst = 1'b1;
      br_taken = 1'b0;
      go();

      // add x5 then immediate reader of x5 on rs1
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      ins(1, 5, 1, 7, 1, 8, 1, 0); mid();
      check("t1_stall", stall, 0);
      go();
      check("t1_fwd_a", fwd_a, 1);
      check("t1_fwd_b", fwd_b, 0);
      check("t1_xvalid", x_valid, 1);
      drain();

      // add x5, nop, nop, reader on rs2
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      nop(); nop();
      ins(1, 1, 1, 5, 1, 9, 1, 0); go();
      check("t2_fwd_b", fwd_b, 3);
      check("t2_fwd_a", fwd_a, 0);
      drain();

      // one nop
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      nop();
      ins(1, 1, 1, 5, 1, 9, 1, 0); go();
      check("t3_fwd_b", fwd_b, 2);
      drain();

      // load-use: one bubble (dut), two bubbles (dut2)
      ins(1, 0, 0, 0, 0, 6, 1, 1); go();
      ins(1, 6, 1, 0, 0, 7, 1, 0); mid();
      check("t4_stall_c1", stall, 1);
      check("t4_bubble_c1", bubble_x, 1);
      check("t4_stall2_c1", stall2, 1);
      go();
      check("t4_fwd_a_held", fwd_a, 0);
      check("t4_xvalid_bub", x_valid, 0);
      mid();
      check("t4_stall_c2", stall, 0);
      check("t4_stall2_c2", stall2, 1);
      go();
      check("t4_fwd_a", fwd_a, 2);
      check("t4_xvalid", x_valid, 1);
      check("t4_xvalid2_bub", x_valid2, 0);
      mid();
      check("t4_stall2_c3", stall2, 0);
      go();
      check("t4_fwd_a2", fwd_a2, 3);
      drain();

      // same rd twice: nearest wins; rs1==rs2
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      ins(1, 5, 1, 5, 1, 9, 1, 0); go();
      check("near_fwd_a", fwd_a, 1);
      check("near_fwd_b", fwd_b, 1);
      drain();

      // producer too old; unused source ignored
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      ins(1, 5, 0, 0, 0, 9, 1, 0); go();
      check("nouse_fwd_a", fwd_a, 0);
      nop(); nop();
      ins(1, 0, 0, 5, 1, 9, 1, 0); go();
      check("old_fwd_b", fwd_b, 0);
      drain();

      // x0 never matches, even for a load
      ins(1, 0, 0, 0, 0, 0, 1, 1); go();
      ins(1, 0, 1, 0, 1, 9, 1, 0); mid();
      check("x0_stall", stall, 0);
      go();
      check("x0_fwd_a", fwd_a, 0);
      check("x0_fwd_b", fwd_b, 0);
      drain();

      // taken branch beats load-use stall
      ins(1, 0, 0, 0, 0, 6, 1, 1); go();
      ins(1, 6, 1, 6, 1, 7, 1, 0);
      br_taken = 1'b1;
      mid();
      check("t6_flush", flush_id, 1);
      check("t6_bubble", bubble_x, 1);
      check("t6_stall", stall, 0);
      go();
      br_taken = 1'b0;
      check("t6_xvalid", x_valid, 0);
      check("t6_fwd_a", fwd_a, 0);
      check("t6_fwd_b", fwd_b, 0);
      drain();

      // reset in the middle of a stall
      ins(1, 0, 0, 0, 0, 5, 1, 0); go();
      ins(1, 5, 1, 0, 0, 6, 1, 1); go();
      ins(1, 6, 1, 0, 0, 7, 1, 0); mid();
      check("t7_stall_pre", stall, 1);
      check("t7_fwd_a_pre", fwd_a, 1);
      #1 rst = 1'b0;
      #1;
      check("t7_stall", stall, 0);
      check("t7_bubble", bubble_x, 0);
      check("t7_flush", flush_id, 0);
      check("t7_xvalid", x_valid, 0);
      check("t7_fwd_a", fwd_a, 0);
      #1 rst = 1'b1;
      go();
      check("t7_post_fwd_a", fwd_a, 0);
      check("t7_post_xvalid", x_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
